// File: rtl/rv_alu_pkg.sv
// Shared types and constants for the RV32I integer ALU.
package rv_alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  // funct3 encoding of the register/immediate ALU operations
  typedef enum logic [2:0] {
    ALU_ADD_SUB = 3'b000,
    ALU_SLL     = 3'b001,
    ALU_SLT     = 3'b010,
    ALU_SLTU    = 3'b011,
    ALU_XOR     = 3'b100,
    ALU_SRL_SRA = 3'b101,
    ALU_OR      = 3'b110,
    ALU_AND     = 3'b111
  } alu_op_e;

endpackage

// File: rtl/rv_alu_shifter.sv
// Combinational 5-stage barrel shifter covering SLL, SRL and SRA.
module rv_alu_shifter
  import rv_alu_pkg::*;
(
  input  logic [XLEN-1:0]    data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir_left,
  input  logic               arith,
  output logic [XLEN-1:0]    result
);

  // Right shifts fill with the sign bit only for SRA; left shifts always zero-fill.
  logic            fill;
  logic [XLEN-1:0] stg [SHAMT_W+1];

  assign fill   = arith & data[XLEN-1];
  assign stg[0] = data;

  // Stage i conditionally shifts by 2^i, selected by shamt[i].
  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int S = 1 << i;
    logic [XLEN-1:0] shl, shr;
    assign shl        = {stg[i][XLEN-1-S:0], {S{1'b0}}};
    assign shr        = {{S{fill}}, stg[i][XLEN-1:S]};
    assign stg[i+1]   = shamt[i] ? (dir_left ? shl : shr) : stg[i];
  end

  assign result = stg[SHAMT_W];

endmodule

// File: rtl/rv_alu.sv
// RV32I execute-stage ALU with a single registered result stage.
module rv_alu
  import rv_alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            funct7,
  input  logic [2:0]      alu_op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] alu_data,
  output logic            out_valid,
  output logic            zero
);

  alu_op_e         op;
  logic            sub;
  logic [XLEN-1:0] b_op;
  logic [XLEN:0]   sum_c;
  logic            lt_u, lt_s;
  logic [XLEN-1:0] shift_res;
  logic [XLEN-1:0] result;

  logic [XLEN-1:0] alu_data_d, alu_data_q;
  logic            zero_d, zero_q;
  logic            out_valid_d, out_valid_q;

  assign op = alu_op_e'(alu_op);

  // Shared adder: compares reuse the subtract path, so they force sub as well.
  always_comb begin
    sub   = ((op == ALU_ADD_SUB) && funct7) || (op == ALU_SLT) || (op == ALU_SLTU);
    b_op  = sub ? ~operand_b : operand_b;
    sum_c = {1'b0, operand_a} + {1'b0, b_op} + {{XLEN{1'b0}}, sub};
    // No carry out of a + ~b + 1 means a borrowed, i.e. a < b unsigned.
    lt_u  = ~sum_c[XLEN];
    // Differing signs cannot overflow the decision: a negative a is the smaller.
    lt_s  = (operand_a[XLEN-1] != operand_b[XLEN-1]) ? operand_a[XLEN-1] : sum_c[XLEN-1];
  end

  rv_alu_shifter u_shifter (
    .data     (operand_a),
    .shamt    (operand_b[SHAMT_W-1:0]),
    .dir_left (op == ALU_SLL),
    .arith    (funct7),
    .result   (shift_res)
  );

  // Result multiplexer; every funct3 code is defined so there is no illegal path.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD_SUB: result = sum_c[XLEN-1:0];
      ALU_SLL:     result = shift_res;
      ALU_SLT:     result = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU:    result = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:     result = operand_a ^ operand_b;
      ALU_SRL_SRA: result = shift_res;
      ALU_OR:      result = operand_a | operand_b;
      ALU_AND:     result = operand_a & operand_b;
      default:     result = '0;
    endcase
  end

  // Next-state: capture on valid input, otherwise hold data/zero and drop valid.
  always_comb begin
    alu_data_d  = alu_data_q;
    zero_d      = zero_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      alu_data_d = result;
      zero_d     = (result == '0);
    end
  end

  // Output register; reset wins over an incoming valid operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_data_q  <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      alu_data_q  <= alu_data_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign alu_data  = alu_data_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rv_alu.sv
// Self-checking bench for rv_alu: directed plan cases plus randomized model checks.
module tb_rv_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        funct7;
  logic [2:0]  alu_op;
  logic [31:0] operand_a, operand_b;
  logic [31:0] alu_data;
  logic        out_valid;
  logic        zero;

  int n_cmp = 0;
  int n_bad = 0;

  rv_alu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .funct7    (funct7),
    .alu_op    (alu_op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .alu_data  (alu_data),
    .out_valid (out_valid),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model straight from the opcode table.
  function automatic logic [31:0] model(input logic f7, input logic [2:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      3'd0: model = f7 ? a - b : a + b;
      3'd1: model = a << sh;
      3'd2: model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: model = (a < b) ? 32'd1 : 32'd0;
      3'd4: model = a ^ b;
      3'd5: model = f7 ? $unsigned($signed(a) >>> sh) : a >> sh;
      3'd6: model = a | b;
      default: model = a & b;
    endcase
  endfunction

  // Apply one valid op, then check the registered result one edge later.
  task automatic op_chk(input string tag, input logic f7, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    in_valid = 1'b1; funct7 = f7; alu_op = op; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    chk(tag, alu_data, exp);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
    chk({tag, ".vld"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1; in_valid = 1'b0; funct7 = 1'b0; alu_op = '0; operand_a = '0; operand_b = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.data", alu_data, 32'd0);
    chk("rst.zero", {31'd0, zero}, 32'd1);
    chk("rst.vld", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;

    // Directed cases, issued back-to-back
    op_chk("add", 0, 3'd0, 32'd7, 32'd5, 32'd12);
    op_chk("sub", 1, 3'd0, 32'd7, 32'd5, 32'd2);
    op_chk("sub_neg", 1, 3'd0, 32'd0, 32'd1, 32'hFFFF_FFFF);
    op_chk("add_wrap", 0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    op_chk("sll4", 0, 3'd1, 32'h8000_0010, 32'd4, 32'h0000_0100);
    op_chk("srl4", 0, 3'd5, 32'h8000_0010, 32'd4, 32'h0800_0001);
    op_chk("sra4", 1, 3'd5, 32'h8000_0010, 32'd4, 32'hF800_0001);
    op_chk("sll_b25", 0, 3'd1, 32'h8000_0010, 32'h25, 32'h0000_0200);
    op_chk("sll_sh0", 0, 3'd1, 32'h8000_0010, 32'h20, 32'h8000_0010);
    op_chk("slt_neg", 0, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'd1);
    op_chk("sltu_big", 0, 3'd3, 32'hFFFF_FFFF, 32'd1, 32'd0);
    op_chk("slt_eq", 0, 3'd2, 32'd3, 32'd3, 32'd0);
    op_chk("sltu_eq", 0, 3'd3, 32'd3, 32'd3, 32'd0);
    op_chk("xor", 0, 3'd4, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
    op_chk("or", 0, 3'd6, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF);
    op_chk("and", 0, 3'd7, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
    op_chk("xor_f7", 1, 3'd4, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
    op_chk("or_f7", 1, 3'd6, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF);
    op_chk("and_f7", 1, 3'd7, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);

    // Hold: in_valid low keeps data, drops valid
    in_valid = 1'b0; operand_a = 32'h1234_5678;
    @(posedge clk); #1;
    chk("hold.data", alu_data, 32'h00F0_000F);
    chk("hold.vld", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("hold2.data", alu_data, 32'h00F0_000F);

    // Reset beats a valid op
    op_chk("pre_rst", 0, 3'd0, 32'd10, 32'd20, 32'd30);
    rst = 1'b1; in_valid = 1'b1; funct7 = 0; alu_op = 3'd6; operand_a = 32'hFF; operand_b = 32'h1;
    @(posedge clk); #1;
    chk("rstv.data", alu_data, 32'd0);
    chk("rstv.zero", {31'd0, zero}, 32'd1);
    chk("rstv.vld", {31'd0, out_valid}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst.vld", {31'd0, out_valid}, 32'd0);

    // Random stream with occasional bubbles
    held = alu_data;
    for (int i = 0; i < 1000; i++) begin
      logic v, f7;
      logic [2:0] op;
      logic [31:0] a, b, e;
      v  = ($urandom_range(0, 4) != 0);
      f7 = 1'($urandom);
      op = 3'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      in_valid = v; funct7 = f7; alu_op = op; operand_a = a; operand_b = b;
      @(posedge clk); #1;
      if (v) held = model(f7, op, a, b);
      e = held;
      chk("rnd.data", alu_data, e);
      chk("rnd.zero", {31'd0, zero}, {31'd0, e == 32'd0});
      chk("rnd.vld", {31'd0, out_valid}, {31'd0, v});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
